// File: rtl/seg7_glyph_decoder_pkg.sv
// Shared seven-segment glyph table: active-low patterns and 3-bit codes.
// Used by the glyph decoder and the matching encoder.
package seg7_glyph_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] CODE_0     = 3'd0;
    localparam logic [2:0] CODE_1     = 3'd1;
    localparam logic [2:0] CODE_2     = 3'd2;
    localparam logic [2:0] CODE_3     = 3'd3;
    localparam logic [2:0] CODE_E     = 3'd4;
    localparam logic [2:0] CODE_H     = 3'd5;
    localparam logic [2:0] CODE_L     = 3'd6;
    localparam logic [2:0] CODE_BLANK = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } glyph_t;

    // Exact match only; anything else is reported as a miss.
    function automatic glyph_t seg7_decode(input logic [6:0] seg);
        glyph_t g;
        g.hit  = 1'b1;
        g.code = CODE_BLANK;
        case (seg)
            SEG_0:     g.code = CODE_0;
            SEG_1:     g.code = CODE_1;
            SEG_2:     g.code = CODE_2;
            SEG_3:     g.code = CODE_3;
            SEG_E:     g.code = CODE_E;
            SEG_H:     g.code = CODE_H;
            SEG_L:     g.code = CODE_L;
            SEG_BLANK: g.code = CODE_BLANK;
            default:   g.hit  = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph_decoder_sync_fifo.sv
// Single-clock FIFO with occupancy, full and empty flags.
// Read data reflects the registered head entry; EMPTY_VAL when empty.
module sync_fifo #(
    parameter int              WIDTH     = 3,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = empty_o ? EMPTY_VAL : mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/seg7_glyph_decoder.sv
// Seven-segment glyph decoder: exact-match decode into an output FIFO,
// with error pulse and saturating error count for unknown patterns.
module seg7_glyph_decoder
    import seg7_glyph_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [6:0]             seg_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [2:0]             code_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err,
    output logic [7:0]             err_count,
    output logic [$clog2(DEPTH):0] level
);

    glyph_t     glyph;
    logic       rdy_q;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       accept;
    logic       push;
    logic       bad;
    logic       pop;
    logic       full;
    logic       empty;

    assign glyph = seg7_decode(seg_in);

    // rdy_q keeps in_ready low through reset and the edge that ends it.
    assign in_ready  = rdy_q && !full;
    assign out_valid = !empty;

    assign accept = in_valid && in_ready;
    assign push   = accept && glyph.hit;
    assign bad    = accept && !glyph.hit;
    assign pop    = out_valid && out_ready;

    always_comb begin
        err_d     = bad;
        err_cnt_d = err_cnt_q;
        if (bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rdy_q     <= 1'b1;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_cnt_q;

    sync_fifo #(
        .WIDTH     (3),
        .DEPTH     (DEPTH),
        .EMPTY_VAL (CODE_BLANK)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push_i  (push),
        .wdata_i (glyph.code),
        .pop_i   (pop),
        .rdata_o (code_out),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_seg7_glyph_decoder.sv
// Scoreboard bench for seg7_glyph_decoder with directed glyph vectors.
module tb_seg7_glyph_decoder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [6:0] seg_in = 7'h7E;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] code_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       err;
    logic [7:0] err_count;
    logic [2:0] level;

    int nchk = 0;
    int nerr = 0;
    logic [2:0] sb[$];

    seg7_glyph_decoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .seg_in    (seg_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_out  (code_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_count (err_count),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge whenever valid and ready.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected: got code %0d expected none", code_out);
            end else begin
                chk("code_out", int'(code_out), int'(sb.pop_front()));
            end
        end
    end

    task automatic send(input logic [6:0] s, input bit hit, input logic [2:0] c);
        int n = 0;
        seg_in   = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        if (hit) sb.push_back(c);
        #1;
        in_valid = 1'b0;
        seg_in   = 7'h7E;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((level != 0 || sb.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_level", int'(level), 0);
        chk("drain_sb", sb.size(), 0);
    endtask

    logic [6:0] seq_s [5] = '{7'h09, 7'h06, 7'h47, 7'h47, 7'h40};
    logic [2:0] seq_c [5] = '{3'd5, 3'd4, 3'd6, 3'd6, 3'd0};
    logic [6:0] fill_s [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_code_out", int'(code_out), 7);
        chk("rst_level", int'(level), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_count", int'(err_count), 0);
        resetn = 1'b1;
        #1;
        chk("ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", int'(in_ready), 1);

        // Ordered stream with out_ready high; each code visible one cycle on
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(seq_s[i], 1'b1, seq_c[i]);
            chk("lat_valid", int'(out_valid), 1);
            chk("lat_code", int'(code_out), int'(seq_c[i]));
            chk("lat_level", int'(level), 1);
        end
        drain();

        // Fill to DEPTH with out_ready low; fifth is held off
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(fill_s[i], 1'b1, 3'(i));
        end
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_level", int'(level), 4);
        seg_in   = 7'h7F;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_level", int'(level), 4);
        chk("held_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pop_same_cycle_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pop_next_ready", int'(in_ready), 1);
        chk("pop_level", int'(level), 3);
        @(posedge clk);
        sb.push_back(3'd7);
        #1;
        in_valid = 1'b0;
        seg_in   = 7'h7E;
        chk("refill_level", int'(level), 4);
        drain();

        // Simultaneous push and pop at level 2
        out_ready = 1'b0;
        send(7'h09, 1'b1, 3'd5);
        send(7'h06, 1'b1, 3'd4);
        chk("pp_level_pre", int'(level), 2);
        out_ready = 1'b1;
        send(7'h47, 1'b1, 3'd6);
        out_ready = 1'b0;
        chk("pp_level_post", int'(level), 2);
        drain();

        // Idle X-free garbage on seg_in must have had no effect
        chk("idle_err_count", int'(err_count), 0);

        // Unrecognised pattern
        send(7'h7E, 1'b0, 3'd0);
        chk("bad_err_pulse", int'(err), 1);
        chk("bad_err_count", int'(err_count), 1);
        chk("bad_level", int'(level), 0);
        chk("bad_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("bad_err_drop", int'(err), 0);
        for (int i = 0; i < 299; i++) begin
            send(7'h7E, 1'b0, 3'd0);
        end
        chk("sat_err_count", int'(err_count), 255);

        // Reset mid-stream with level 3
        out_ready = 1'b0;
        send(7'h40, 1'b1, 3'd0);
        send(7'h79, 1'b1, 3'd1);
        send(7'h24, 1'b1, 3'd2);
        chk("mid_level", int'(level), 3);
        resetn = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_code_out", int'(code_out), 7);
        chk("mid_rst_err_count", int'(err_count), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ready_back", int'(in_ready), 1);
        chk("mid_discarded", int'(out_valid), 0);
        out_ready = 1'b1;
        send(7'h79, 1'b1, 3'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/seg7_glyph_decoder.md
SEG7_GLYPH_DECODER -- requirements
Module: seg7_glyph_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port seg_in, input, 7, active-low segment pattern, bit0=a ... bit6=g.
REQ-005 SHALL have port in_valid, input, 1, seg_in is presented.
REQ-006 SHALL have port in_ready, output, 1, block can accept seg_in this cycle.
REQ-007 SHALL have port code_out, output, 3, decoded glyph code at FIFO head.
REQ-008 SHALL have port out_valid, output, 1, code_out holds a valid entry.
REQ-009 SHALL have port out_ready, input, 1, consumer takes code_out this cycle.
REQ-010 SHALL have port err, output, 1, one-cycle pulse for each accepted unrecognised pattern.
REQ-011 SHALL have port err_count, output, 8, saturating count of unrecognised patterns.
REQ-012 SHALL have port level, output, clog2(DEPTH)+1, current FIFO occupancy.

Function
REQ-013 SHALL decode via exact match: 0x40->0 ('0'), 0x79->1 ('1'), 0x24->2 ('2'), 0x30->3 ('3'), 0x06->4 ('E'), 0x09->5 ('H'), 0x47->6 ('L'), 0x7F->7 (blank).
REQ-014 SHALL treat any other seg_in value as unrecognised; no partial or nearest match.
REQ-015 SHALL accept an input when in_valid and in_ready are both high at a rising edge.
REQ-016 SHALL drive in_ready = (level < DEPTH); no combinational path from out_ready to in_ready.
REQ-017 SHALL push a recognised accepted code to the FIFO tail on the accept edge.
REQ-018 SHALL consume an unrecognised accepted pattern without pushing it, pulse err for the following cycle, and increment err_count, holding at 255.
REQ-019 SHALL pop the head when out_valid and out_ready are both high at a rising edge.
REQ-020 SHALL drive out_valid = (level != 0) and code_out from the registered head entry; latency from accept edge to out_valid is one cycle, with no same-cycle bypass.
REQ-021 SHALL leave level unchanged on a simultaneous push and pop; wrap read and write pointers modulo DEPTH.
REQ-022 SHALL, when full with a pop, raise in_ready only in the next cycle.
REQ-023 SHALL hold code_out stable while out_valid is high and out_ready is low.
REQ-024 SHALL ignore seg_in whenever in_valid is low; X on seg_in while in_valid is low SHALL NOT affect state.

Reset
REQ-025 SHALL, on resetn low, immediately clear level, pointers, err and err_count, and drive out_valid=0, in_ready=0, and code_out=3'd7.
REQ-026 SHALL drive in_ready=1 from the first clock edge after resetn deasserts; reset mid-transfer SHALL discard all FIFO contents.

Structure
REQ-027 SHALL place the glyph pattern constants and the 3-bit code values in the shared seg7 package, for reuse by the matching encoder.
REQ-028 SHALL instantiate one sub-module, sync_fifo, which is parameterised by width 3 and DEPTH and provides level, full and empty.
REQ-029 SHALL keep decode combinational ahead of the FIFO push, with no additional pipeline register.

Verification
REQ-030 SHALL cover this sequence: after reset, push 0x09, 0x06, 0x47, 0x47, 0x40 with out_ready=1 -> codes 5,4,6,6,0 in order, each appearing one cycle after acceptance.
REQ-031 SHALL cover this case: out_ready=0 and push 5 recognised patterns with DEPTH=4 -> in_ready falls after the 4th accept, the 5th is held, and level=4.
REQ-032 SHALL cover this case: full FIFO, out_ready=1 for one cycle -> one pop, and in_ready rises the next cycle, not the same cycle.
REQ-033 SHALL cover this case: push 0x7E -> nothing queued, err high for exactly one cycle, and err_count=1; 300 such pushes -> err_count=255.
REQ-034 SHALL cover this case: simultaneous push and pop at level=2 -> level stays 2, and order is preserved.
REQ-035 SHALL cover this case: resetn asserted with level=3 mid-stream -> out_valid=0, code_out=7, and err_count=0 immediately.
